bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble). Sits directly upstream of the two-digit seven-segment BCD display stage. Converts a binary count (e.g. a ROM or counter value) into packed BCD digits for that stage's 8-bit BCD input. Uses a start/busy/done handshake, one bit per clock, and holds the result between conversions.

---
 rtl/bin_to_bcd_seq.sv | 158 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   One input bit is consumed per clock. The result is held between
//   conversions and feeds the two-digit seven-segment BCD display stage.
//
// Parameters
//   BIN_W   width of the binary input (4..16)
//   DIGITS  number of BCD digits presented on bcd_out (1..5)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    conversion request, only honoured while idle
//   bin_in   binary value, captured when start is accepted
//   busy     high while converting, through the done-state cycle
//   done     single-cycle pulse when bcd_out/ovf update
//   bcd_out  packed BCD, most-significant digit in the top nibble
//   ovf      value did not fit in DIGITS digits; held with bcd_out
//
// Build option
//   SAT_EN   when defined, an overflowing result shows all nines on bcd_out;
//            otherwise the low DIGITS digits of the true value are shown.
//
// State table
//   ST_IDLE  | waiting for start, outputs held
//   ST_SHIFT | add-3 correction and one-bit shift per clock, BIN_W cycles
//   ST_DONE  | final accumulator is registered onto bcd_out/ovf, done raised
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    // ceil(BIN_W/3)+1 digits always hold the full value of a BIN_W-bit input.
    localparam int INT_D = (BIN_W + 2) / 3 + 1;
    localparam int MAX_D = (INT_D > DIGITS) ? INT_D : DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [BIN_W-1:0]    shreg_q,   shreg_d;
    logic [4*INT_D-1:0]  acc_q,     acc_d;
    logic                done_q,    done_d;
    logic [4*DIGITS-1:0] bcd_q,     bcd_d;
    logic                ovf_q,     ovf_d;

    logic [4*INT_D-1:0]  acc_adj;
    logic [4*MAX_D-1:0]  acc_ext;
    logic [4*DIGITS-1:0] bcd_trunc;
    logic                acc_ovf;

    // Add-3 correction on every digit, all digits in parallel.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < INT_D; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end else begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4];
            end
        end
    end

    // Zero-extension lets DIGITS exceed INT_D; then the ovf loop only sees
    // padding zeros and ovf stays 0.
    always_comb begin
        acc_ext = '0;
        acc_ext[4*INT_D-1:0] = acc_q;
        bcd_trunc = acc_ext[4*DIGITS-1:0];
        acc_ovf = 1'b0;
        for (int i = DIGITS; i < MAX_D; i++) begin
            if (acc_ext[4*i +: 4] != 4'd0) begin
                acc_ovf = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = bin_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                // Counter hits zero with this shift, which is the last one.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                ovf_d  = acc_ovf;
`ifdef SAT_EN
                bcd_d  = acc_ovf ? {DIGITS{4'h9}} : bcd_trunc;
`else
                bcd_d  = bcd_trunc;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq. Two instances: the default
//   8-bit / 2-digit build and a 12-bit / 4-digit build. Expected values come
//   from a decimal-arithmetic reference model and a fixed vector table.
//   Honours SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

`ifdef SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start12;
    logic [7:0]  bin8;
    logic [11:0] bin12;
    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
    logic        busy12, done12, ovf12;
    logic [15:0] bcd12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut (
        .clk(clk), .rst(rst), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8), .ovf(ovf8)
    );

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .bin_in(bin12),
        .busy(busy12), .done(done12), .bcd_out(bcd12), .ovf(ovf12)
    );

    typedef struct {
        int         bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, overflow by magnitude.
    function automatic void ref_model(input int v, input int nd,
                                      output logic [15:0] bcd, output logic o);
        int t;
        int lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        o = (v >= lim);
        bcd = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (o && SAT) begin
            for (int i = 0; i < nd; i++) bcd[4*i +: 4] = 4'h9;
        end
    endfunction

    function automatic logic cur_done(input int w);
        return (w == 8) ? done8 : done12;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 8) ? busy8 : busy12;
    endfunction

    function automatic logic [15:0] cur_bcd(input int w);
        return (w == 8) ? {8'h00, bcd8} : bcd12;
    endfunction

    function automatic logic cur_ovf(input int w);
        return (w == 8) ? ovf8 : ovf12;
    endfunction

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat = clock edges from the start edge to done being visible.
    task automatic run_conv(input int w, input int v, output int lat, output int bc,
                            output logic [15:0] bcd, output logic o, output logic held);
        logic [15:0] prev;
        prev = cur_bcd(w);
        if (w == 8) begin
            bin8 = v[7:0];
            start8 = 1'b1;
        end else begin
            bin12 = v[11:0];
            start12 = 1'b1;
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        start12 = 1'b0;
        lat = 0;
        bc = 0;
        held = 1'b1;
        while (!cur_done(w) && lat < 40) begin
            if (cur_busy(w)) bc++;
            if (cur_bcd(w) !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bcd = cur_bcd(w);
        o = cur_ovf(w);
    endtask

    task automatic check_conv(input int w, input int v, input logic [15:0] exp_bcd,
                              input logic exp_ovf, input string tag);
        int lat, bc;
        logic [15:0] bcd;
        logic o, held;
        run_conv(w, v, lat, bc, bcd, o, held);
        chk({tag, " latency"}, lat, w + 1);
        chk({tag, " busy_cycles"}, bc, w + 1);
        chk({tag, " bcd_out"}, bcd, exp_bcd);
        chk({tag, " ovf"}, o, exp_ovf);
        chk({tag, " held_until_done"}, held, 1'b1);
        @(posedge clk); #1;
        chk({tag, " done_single_pulse"}, cur_done(w), 1'b0);
    endtask

    initial begin
        logic [15:0] eb;
        logic        eo;
        int          k;
        int          v;

        vecs[0] = '{42,  8'h42, 1'b0};
        vecs[1] = '{0,   8'h00, 1'b0};
        vecs[2] = '{99,  8'h99, 1'b0};
        vecs[3] = '{255, SAT ? 8'h99 : 8'h55, 1'b1};
        vecs[4] = '{100, SAT ? 8'h99 : 8'h00, 1'b1};
        vecs[5] = '{9,   8'h09, 1'b0};
        vecs[6] = '{10,  8'h10, 1'b0};
        vecs[7] = '{199, 8'h99, 1'b1};

        // Reset held together with start: reset must win.
        rst = 1'b1;
        start8 = 1'b1;
        start12 = 1'b1;
        bin8 = 8'd200;
        bin12 = 12'd0;
        #1;
        chk("reset busy", busy8, 1'b0);
        chk("reset done", done8, 1'b0);
        chk("reset bcd_out", bcd8, 8'h00);
        chk("reset ovf", ovf8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_with_start busy", busy8, 1'b0);
        chk("reset_with_start busy12", busy12, 1'b0);
        start8 = 1'b0;
        start12 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            check_conv(8, vecs[i].bin, {8'h00, vecs[i].bcd}, vecs[i].ovf,
                       $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 255));
            ref_model(v, 2, eb, eo);
            check_conv(8, v, eb, eo, $sformatf("rand8_%0d", v));
        end

        // start held high through the whole busy window with bin_in changed.
        bin8 = 8'd42;
        start8 = 1'b1;
        @(posedge clk); #1;
        bin8 = 8'd7;
        k = 0;
        while (!done8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("held_start first latency", k, 9);
        chk("held_start first bcd_out", bcd8, 8'h42);
        k = 0;
        @(posedge clk); #1;
        k++;
        while (!done8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        start8 = 1'b0;
        chk("held_start second gap", k, 10);
        chk("held_start second bcd_out", bcd8, 8'h07);
        @(posedge clk); #1;

        check_conv(8, 255, SAT ? 16'h0099 : 16'h0055, 1'b1, "pre_reset 255");

        // Reset in cycle 4 of SHIFT while an earlier result is displayed.
        bin8 = 8'd87;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset pre busy", busy8, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_reset busy", busy8, 1'b0);
        chk("mid_reset done", done8, 1'b0);
        chk("mid_reset bcd_out", bcd8, 8'h00);
        chk("mid_reset ovf", ovf8, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_conv(8, 13, 16'h0013, 1'b0, "post_reset 13");

        check_conv(12, 4095, 16'h4095, 1'b0, "w12 4095");
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 4095));
            ref_model(v, 4, eb, eo);
            check_conv(12, v, eb, eo, $sformatf("rand12_%0d", v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
